// File: rtl/sig16b_conv_scheduler.sv
// sig16b_conv_scheduler
// Shares one double-to-16-bit signed-magnitude converter between N_REQ
// requesters. Requests are granted round-robin, the granted double is
// latched and issued with a single-cycle enable, and after the converter
// latency the result is returned tagged with the owning requester index.
// Conversion and saturation counters are kept for the debug readout.
//
// Ports:
//   clk_sampling  sampling clock, rising edge
//   rst           asynchronous active-high reset
//   req_valid     per-requester request, held until req_ready is seen
//   req_double    one IEEE-754 double per requester, slice i = [64*i+63:64*i]
//   req_ready     one-hot accept (combinational, IDLE only)
//   conv_enable   single-cycle enable to the converter
//   conv_double   registered operand to the converter
//   conv_sig16b   converter result (bit 15 sign, [14:0] magnitude)
//   res_valid     single-cycle result strobe
//   res_id        requester index owning res_data
//   res_data      captured converter result
//   busy          high whenever not IDLE
//   conv_count    completed conversions, saturating
//   sat_count     results with full-scale magnitude, saturating
module sig16b_conv_scheduler #(
  parameter int N_REQ    = 2,
  parameter int CONV_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic                 clk_sampling,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_valid,
  input  logic [64*N_REQ-1:0]  req_double,
  output logic [N_REQ-1:0]     req_ready,
  output logic                 conv_enable,
  output logic [63:0]          conv_double,
  input  logic [15:0]          conv_sig16b,
  output logic                 res_valid,
  output logic [2:0]           res_id,
  output logic [15:0]          res_data,
  output logic                 busy,
  output logic [CNT_W-1:0]     conv_count,
  output logic [CNT_W-1:0]     sat_count
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  state_t      state, state_next;
  logic [2:0]  rr;
  logic [2:0]  gi;
  logic [1:0]  wait_cnt;
  logic [2:0]  grant;
  logic        grant_found;
  logic        handshake;
  logic [63:0] grant_double;

  // Round-robin search: first valid requester starting at rr, wrapping.
  always_comb begin
    int idx;
    grant       = rr;
    grant_found = 1'b0;
    idx         = 0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!grant_found && req_valid[idx]) begin
        grant       = 3'(idx);
        grant_found = 1'b1;
      end
    end
  end

  // One-hot accept and operand mux for the granted requester. Ready is
  // suppressed while reset is held so nothing is accepted at release.
  always_comb begin
    req_ready    = '0;
    grant_double = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (grant == 3'(i)) begin
        grant_double = req_double[64*i +: 64];
        req_ready[i] = (state == IDLE) && grant_found && !rst;
      end
    end
  end

  assign handshake = |(req_valid & req_ready);

  // Next-state and Moore outputs.
  always_comb begin
    state_next  = state;
    conv_enable = 1'b0;
    res_valid   = 1'b0;
    busy        = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (handshake) state_next = ISSUE;
      end
      ISSUE: begin
        conv_enable = 1'b1;
        state_next  = WAIT;
      end
      WAIT: begin
        if (wait_cnt == 2'd0) state_next = DONE;
      end
      DONE: begin
        res_valid  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State register and datapath. The wait counter is loaded in ISSUE so
  // WAIT lasts exactly CONV_LAT cycles; the result is captured on the last.
  always_ff @(posedge clk_sampling or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      rr          <= '0;
      gi          <= '0;
      wait_cnt    <= '0;
      conv_double <= '0;
      res_id      <= '0;
      res_data    <= '0;
      conv_count  <= '0;
      sat_count   <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (handshake) begin
            conv_double <= grant_double;
            gi          <= grant;
          end
        end
        ISSUE: begin
          wait_cnt <= 2'(CONV_LAT - 1);
        end
        WAIT: begin
          if (wait_cnt == 2'd0) begin
            res_data <= conv_sig16b;
            res_id   <= gi;
          end else begin
            wait_cnt <= wait_cnt - 2'd1;
          end
        end
        DONE: begin
          if (conv_count != '1) conv_count <= conv_count + 1'b1;
          if (res_data[14:0] == 15'h7FFF && sat_count != '1)
            sat_count <= sat_count + 1'b1;
          rr <= (gi == 3'(N_REQ - 1)) ? 3'd0 : gi + 3'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sig16b_conv_scheduler.sv
// Testbench for sig16b_conv_scheduler: converter stub plus a transaction-
// level reference model (round-robin over pending requests, fixed latency,
// saturating counters).
module tb_sig16b_conv_scheduler;

  localparam int N_REQ    = 3;
  localparam int CONV_LAT = 3;
  localparam int CNT_W    = 4;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                clk_sampling;
  logic                rst;
  logic [N_REQ-1:0]    req_valid;
  logic [64*N_REQ-1:0] req_double;
  logic [N_REQ-1:0]    req_ready;
  logic                conv_enable;
  logic [63:0]         conv_double;
  logic [15:0]         conv_sig16b;
  logic                res_valid;
  logic [2:0]          res_id;
  logic [15:0]         res_data;
  logic                busy;
  logic [CNT_W-1:0]    conv_count;
  logic [CNT_W-1:0]    sat_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // Reference model state
  int mdl_rr   = 0;
  int mdl_conv = 0;
  int mdl_sat  = 0;

  sig16b_conv_scheduler #(.N_REQ(N_REQ), .CONV_LAT(CONV_LAT), .CNT_W(CNT_W)) dut (
    .clk_sampling(clk_sampling),
    .rst(rst),
    .req_valid(req_valid),
    .req_double(req_double),
    .req_ready(req_ready),
    .conv_enable(conv_enable),
    .conv_double(conv_double),
    .conv_sig16b(conv_sig16b),
    .res_valid(res_valid),
    .res_id(res_id),
    .res_data(res_data),
    .busy(busy),
    .conv_count(conv_count),
    .sat_count(sat_count)
  );

  initial clk_sampling = 1'b0;
  always #5 clk_sampling = ~clk_sampling;

  // Converter stub: low 16 bits of the operand appear CONV_LAT edges after
  // the enable edge; outside that window it returns the inverted value.
  logic [15:0] stub_data [CONV_LAT];
  logic        stub_vld  [CONV_LAT];
  always @(posedge clk_sampling) begin
    stub_data[0] <= conv_double[15:0];
    stub_vld[0]  <= conv_enable;
    for (int k = 1; k < CONV_LAT; k++) begin
      stub_data[k] <= stub_data[k-1];
      stub_vld[k]  <= stub_vld[k-1];
    end
  end
  assign conv_sig16b = stub_vld[CONV_LAT-1] ? stub_data[CONV_LAT-1] : ~stub_data[CONV_LAT-1];

  initial begin
    #300000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_sampling);
    #1;
    cyc++;
  endtask

  task automatic model_result(input logic [15:0] d);
    if (mdl_conv < CNT_MAX) mdl_conv++;
    if (d[14:0] == 15'h7FFF && mdl_sat < CNT_MAX) mdl_sat++;
  endtask

  task automatic apply_reset();
    req_valid  = '0;
    req_double = '0;
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    mdl_rr = 0; mdl_conv = 0; mdl_sat = 0;
  endtask

  // Waits (bounded) for the result strobe; reports how many ticks it took.
  task automatic wait_result(output bit got, output int cycles);
    cycles = 0;
    while (!res_valid && cycles < 40) begin
      tick();
      cycles++;
    end
    got = res_valid;
  endtask

  // Single-requester transaction from IDLE; returns what the DUT produced.
  task automatic run_one(input int id, input logic [63:0] d,
                         output bit got, output logic [2:0] rid, output logic [15:0] rdata);
    int cycles;
    req_double[64*id +: 64] = d;
    req_valid = '0;
    req_valid[id] = 1'b1;
    #1;
    tick();
    req_valid = '0;
    wait_result(got, cycles);
    rid = res_id;
    rdata = res_data;
    tick();
  endtask

  task automatic test_reset();
    req_valid = '0;
    req_double = '0;
    rst = 1'b1;
    tick();
    total++; if (busy !== 1'b0) begin bad++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    total++; if (conv_enable !== 1'b0) begin bad++; $display("[TB] FAIL reset_en: got %b expected 0", conv_enable); end
    total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid: got %b expected 0", res_valid); end
    total++; if (conv_double !== 64'h0) begin bad++; $display("[TB] FAIL reset_double: got %h expected 0", conv_double); end
    total++; if ({res_id, res_data} !== 19'h0) begin bad++; $display("[TB] FAIL reset_res: got %h/%h expected 0", res_id, res_data); end
    total++; if ({conv_count, sat_count} !== '0) begin bad++; $display("[TB] FAIL reset_cnt: got %h/%h expected 0", conv_count, sat_count); end
    total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 0", req_ready); end
    rst = 1'b0;
    tick();
    mdl_rr = 0; mdl_conv = 0; mdl_sat = 0;
  endtask

  // Cycle-by-cycle timing of one isolated request on requester 0.
  task automatic test_single();
    logic [63:0] d;
    d = 64'h0000_0000_0000_1234;
    req_double[63:0] = d;
    req_valid = 3'b001;
    #1;
    total++; if (req_ready !== 3'b001) begin bad++; $display("[TB] FAIL single_ready: got %b expected 001", req_ready); end
    for (int c = 1; c <= CONV_LAT + 3; c++) begin
      tick();
      if (c == 1) begin
        req_valid = '0;
        total++; if (conv_double !== d) begin bad++; $display("[TB] FAIL single_operand: got %h expected %h", conv_double, d); end
      end
      total++; if (conv_enable !== (c == 1)) begin bad++; $display("[TB] FAIL single_en c%0d: got %b expected %b", c, conv_enable, c == 1); end
      total++; if (res_valid !== (c == CONV_LAT + 2)) begin bad++; $display("[TB] FAIL single_valid c%0d: got %b expected %b", c, res_valid, c == CONV_LAT + 2); end
      total++; if (busy !== (c <= CONV_LAT + 2)) begin bad++; $display("[TB] FAIL single_busy c%0d: got %b expected %b", c, busy, c <= CONV_LAT + 2); end
      if (c == CONV_LAT + 2) begin
        total++; if (res_data !== 16'h1234 || res_id !== 3'd0) begin bad++; $display("[TB] FAIL single_result: got id%0d %h expected id0 1234", res_id, res_data); end
        model_result(16'h1234);
        mdl_rr = 1;
      end
    end
    total++; if (conv_count !== CNT_W'(mdl_conv)) begin bad++; $display("[TB] FAIL single_count: got %0d expected %0d", conv_count, mdl_conv); end
  endtask

  // All requesters continuously valid: strict rotation and fixed spacing.
  task automatic test_contention();
    logic [15:0] low [N_REQ];
    int last_cyc, cycles, g;
    bit got;
    for (int i = 0; i < N_REQ; i++) begin
      low[i] = 16'($urandom);
      req_double[64*i +: 64] = {32'($urandom), 16'($urandom), low[i]};
    end
    req_valid = '1;
    #1;
    last_cyc = -1;
    for (int n = 0; n < 2 * N_REQ; n++) begin
      logic [N_REQ-1:0] exp_rdy;
      g = mdl_rr;
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL cont_ready n%0d: got %b expected %b", n, req_ready, exp_rdy); end
      tick();
      wait_result(got, cycles);
      total++; if (!got || res_id !== 3'(g) || res_data !== low[g]) begin
        bad++; $display("[TB] FAIL cont_result n%0d: got v%0d id%0d %h expected id%0d %h", n, got, res_id, res_data, g, low[g]);
      end
      if (last_cyc >= 0) begin
        total++; if (cyc - last_cyc !== CONV_LAT + 3) begin bad++; $display("[TB] FAIL cont_spacing n%0d: got %0d expected %0d", n, cyc - last_cyc, CONV_LAT + 3); end
      end
      last_cyc = cyc;
      model_result(low[g]);
      mdl_rr = (g + 1) % N_REQ;
      tick();
    end
    req_valid = '0;
    #1;
    total++; if (conv_count !== CNT_W'(mdl_conv)) begin bad++; $display("[TB] FAIL cont_count: got %0d expected %0d", conv_count, mdl_conv); end
  endtask

  // Requester 1 arrives mid-conversion and must wait for the next IDLE.
  task automatic test_hold_busy();
    bit got;
    int cycles;
    logic [63:0] d1;
    logic [N_REQ-1:0] exp_rdy;
    d1 = {$urandom, $urandom};
    req_double[63:0] = {$urandom, $urandom};
    req_valid = 3'b001;
    #1;
    tick();
    model_result(conv_double[15:0]);
    req_valid = 3'b010;
    req_double[127:64] = d1;
    #1;
    cycles = 0;
    while (!res_valid && cycles < 40) begin
      total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL hold_ready_busy: got %b expected 000", req_ready); end
      tick();
      cycles++;
    end
    total++; if (!res_valid || res_id !== 3'd0) begin bad++; $display("[TB] FAIL hold_first: got v%b id%0d expected v1 id0", res_valid, res_id); end
    total++; if (req_ready !== '0) begin bad++; $display("[TB] FAIL hold_ready_done: got %b expected 000", req_ready); end
    mdl_rr = 1;
    tick();
    exp_rdy = '0;
    exp_rdy[1] = 1'b1;
    total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL hold_ready_idle: got %b expected %b", req_ready, exp_rdy); end
    tick();
    req_valid = '0;
    wait_result(got, cycles);
    total++; if (!got || res_id !== 3'd1 || res_data !== d1[15:0]) begin
      bad++; $display("[TB] FAIL hold_result: got v%0d id%0d %h expected id1 %h", got, res_id, res_data, d1[15:0]);
    end
    model_result(d1[15:0]);
    mdl_rr = 2 % N_REQ;
    tick();
  endtask

  // Random arrivals; grant predicted from the pending set and rr.
  task automatic test_random();
    logic [N_REQ-1:0] pending;
    logic [15:0] low [N_REQ];
    bit got;
    int cycles, g;
    pending = '0;
    for (int n = 0; n < 12; n++) begin
      logic [N_REQ-1:0] exp_rdy;
      if (pending == '0) begin
        req_valid = '0;
        #1;
        total++; if (req_ready !== '0 || busy !== 1'b0) begin bad++; $display("[TB] FAIL rand_idle: got %b/%b expected 000/0", req_ready, busy); end
        tick();
      end
      for (int i = 0; i < N_REQ; i++) begin
        if (!pending[i] && ($urandom_range(0, 1) == 1 || (pending == '0 && i == N_REQ - 1))) begin
          pending[i] = 1'b1;
          low[i] = 16'($urandom);
          req_double[64*i +: 64] = {32'($urandom), 16'($urandom), low[i]};
        end
      end
      req_valid = pending;
      #1;
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (mdl_rr + k) % N_REQ;
        if (g < 0 && pending[idx]) g = idx;
      end
      exp_rdy = '0;
      exp_rdy[g] = 1'b1;
      total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL rand_ready n%0d: got %b expected %b", n, req_ready, exp_rdy); end
      tick();
      pending[g] = 1'b0;
      req_valid = pending;
      wait_result(got, cycles);
      total++; if (!got || cycles !== CONV_LAT + 1 || res_id !== 3'(g) || res_data !== low[g]) begin
        bad++; $display("[TB] FAIL rand_result n%0d: got v%0d lat%0d id%0d %h expected lat%0d id%0d %h",
                        n, got, cycles, res_id, res_data, CONV_LAT + 1, g, low[g]);
      end
      model_result(low[g]);
      mdl_rr = (g + 1) % N_REQ;
      tick();
    end
    // Drain whatever is still pending so later tests start clean.
    while (pending != '0) begin
      g = -1;
      for (int k = 0; k < N_REQ; k++) begin
        int idx;
        idx = (mdl_rr + k) % N_REQ;
        if (g < 0 && pending[idx]) g = idx;
      end
      tick();
      pending[g] = 1'b0;
      req_valid = pending;
      wait_result(got, cycles);
      model_result(low[g]);
      mdl_rr = (g + 1) % N_REQ;
      tick();
    end
    total++; if (conv_count !== CNT_W'(mdl_conv) || sat_count !== CNT_W'(mdl_sat)) begin
      bad++; $display("[TB] FAIL rand_counts: got %0d/%0d expected %0d/%0d", conv_count, sat_count, mdl_conv, mdl_sat);
    end
  endtask

  task automatic test_saturation();
    logic [15:0] pat [3];
    bit got;
    logic [2:0] rid;
    logic [15:0] rdata;
    pat[0] = 16'hFFFF; pat[1] = 16'h7FFF; pat[2] = 16'h0001;
    apply_reset();
    for (int n = 0; n < 3; n++) begin
      run_one(0, {48'($urandom), pat[n]}, got, rid, rdata);
      total++; if (!got || rdata !== pat[n]) begin bad++; $display("[TB] FAIL sat_result n%0d: got v%0d %h expected %h", n, got, rdata, pat[n]); end
      model_result(pat[n]);
    end
    total++; if (conv_count !== CNT_W'(3) || sat_count !== CNT_W'(2)) begin
      bad++; $display("[TB] FAIL sat_counts: got %0d/%0d expected 3/2", conv_count, sat_count);
    end
    for (int n = 0; n < CNT_MAX + 2; n++) begin
      run_one(0, {48'($urandom), 16'h7FFF}, got, rid, rdata);
      model_result(16'h7FFF);
    end
    total++; if (conv_count !== CNT_W'(mdl_conv) || sat_count !== CNT_W'(mdl_sat)) begin
      bad++; $display("[TB] FAIL sat_full: got %0d/%0d expected %0d/%0d", conv_count, sat_count, mdl_conv, mdl_sat);
    end
    for (int n = 0; n < 3; n++) begin
      run_one(0, {48'($urandom), pat[n]}, got, rid, rdata);
      model_result(pat[n]);
    end
    total++; if (conv_count !== '1 || sat_count !== '1) begin
      bad++; $display("[TB] FAIL sat_hold: got %0d/%0d expected %0d/%0d", conv_count, sat_count, CNT_MAX, CNT_MAX);
    end
    mdl_rr = 1;
  endtask

  // Reset during WAIT abandons the conversion; rr restarts at requester 0.
  task automatic test_mid_reset();
    bit got;
    int cycles;
    logic [63:0] d0;
    logic [N_REQ-1:0] exp_rdy;
    d0 = {$urandom, $urandom};
    req_double[127:64] = {$urandom, $urandom};
    req_valid = 3'b010;
    #1;
    tick();
    tick();
    req_double[63:0] = d0;
    req_valid = 3'b011;
    #1;
    rst = 1'b1;
    #1;
    total++; if (busy !== 1'b0 || conv_enable !== 1'b0 || res_valid !== 1'b0 || req_ready !== '0) begin
      bad++; $display("[TB] FAIL mrst_ctrl: got busy%b en%b v%b rdy%b expected all 0", busy, conv_enable, res_valid, req_ready);
    end
    total++; if (conv_double !== 64'h0 || res_id !== 3'd0 || res_data !== 16'h0 || conv_count !== '0 || sat_count !== '0) begin
      bad++; $display("[TB] FAIL mrst_data: got %h %0d %h %0d %0d expected all 0", conv_double, res_id, res_data, conv_count, sat_count);
    end
    tick();
    rst = 1'b0;
    mdl_rr = 0; mdl_conv = 0; mdl_sat = 0;
    #1;
    exp_rdy = '0;
    exp_rdy[0] = 1'b1;
    total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL mrst_grant: got %b expected %b", req_ready, exp_rdy); end
    for (int c = 1; c <= CONV_LAT + 1; c++) begin
      tick();
      if (c == 1) req_valid = 3'b010;
      total++; if (res_valid !== 1'b0) begin bad++; $display("[TB] FAIL mrst_stale c%0d: got %b expected 0", c, res_valid); end
    end
    tick();
    total++; if (res_valid !== 1'b1 || res_id !== 3'd0 || res_data !== d0[15:0]) begin
      bad++; $display("[TB] FAIL mrst_result: got v%b id%0d %h expected v1 id0 %h", res_valid, res_id, res_data, d0[15:0]);
    end
    tick();
    exp_rdy = '0;
    exp_rdy[1] = 1'b1;
    total++; if (req_ready !== exp_rdy) begin bad++; $display("[TB] FAIL mrst_next: got %b expected %b", req_ready, exp_rdy); end
    tick();
    req_valid = '0;
    wait_result(got, cycles);
    total++; if (!got || res_id !== 3'd1) begin bad++; $display("[TB] FAIL mrst_pending: got v%0d id%0d expected id1", got, res_id); end
    tick();
    total++; if (conv_count !== CNT_W'(2)) begin bad++; $display("[TB] FAIL mrst_count: got %0d expected 2", conv_count); end
  endtask

  initial begin
    rst = 1'b0;
    req_valid = '0;
    req_double = '0;
    #2;
    test_reset();
    test_single();
    test_contention();
    test_hold_busy();
    test_random();
    test_saturation();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sig16b_conv_scheduler.md
Name: sig16b_conv_scheduler

Overview:
- Shares one double-to-16-bit signed-magnitude converter between N_REQ requesters in the echo-cancellation datapath (e.g. echo estimate, error signal, monitor tap).
- Grants requesters round-robin, latches the granted double and pulses the converter enable.
- Waits the converter latency, then returns the 16-bit result tagged with the requester index.
- Keeps a conversion count and a saturation count for the debug readout.

Parameters:
- N_REQ, 2: number of requesters; 2..8.
- CONV_LAT, 1: cycles from the converter enable edge until its output is valid; 1..4.
- CNT_W, 16: width of the conversion and saturation counters.

Ports:
- clk_sampling  in  1  sampling clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request.
- req_double  in  64*N_REQ  IEEE-754 double per requester; slice i is [64*i+63:64*i].
- req_ready  out  N_REQ  one-hot accept, combinational.
- conv_enable  out  1  enable to the converter.
- conv_double  out  64  registered operand to the converter.
- conv_sig16b  in  16  converter result: bit 15 is sign, [14:0] is magnitude.
- res_valid  out  1  single-cycle result strobe.
- res_id  out  3  index of the requester that owns res_data.
- res_data  out  16  captured converter result.
- busy  out  1  high in any state other than IDLE.
- conv_count  out  CNT_W  completed conversions; saturates at all-ones.
- sat_count  out  CNT_W  results with magnitude 15'h7FFF; saturates at all-ones.

Behaviour:
- States are IDLE, ISSUE, WAIT, DONE. Reset state is IDLE.
- Reset values:
  - req_ready=0, conv_enable=0, conv_double=0, res_valid=0, res_id=0, res_data=0, busy=0.
  - Both counters 0; round-robin pointer rr=0.
- IDLE:
  - grant g is the first i with req_valid[i]=1, searching from rr upward and wrapping modulo N_REQ.
  - req_ready[g]=1, all other bits 0. With no request, req_ready=0 and the state stays IDLE.
  - A handshake occurs when req_valid[g] and req_ready[g] are both high at an edge.
  - At the handshake edge: conv_double<=req_double slice g, grant register gi<=g, go to ISSUE.
- req_ready is 0 in every other state. A requester holds req_valid and its data until it sees req_ready.
- ISSUE:
  - conv_enable=1 for exactly this cycle.
  - At the end of the cycle: wait counter<=CONV_LAT-1, go to WAIT.
- WAIT:
  - Lasts CONV_LAT cycles; the counter decrements each cycle.
  - In the last WAIT cycle, conv_sig16b is captured: res_data<=conv_sig16b, res_id<=gi. Then go to DONE.
- DONE:
  - res_valid=1 for this cycle only.
  - conv_count increments; sat_count increments if res_data[14:0]==15'h7FFF. Both counters saturate, never wrap.
  - At the end of the cycle: rr<=(gi+1) mod N_REQ, go to IDLE.
- Timing: an accept at edge t gives conv_enable in cycle t+1 and res_valid in cycle t+2+CONV_LAT. Period per conversion is CONV_LAT+3 cycles.
- conv_double holds its value from accept until the next accept; it is never cleared except by reset.
- res_data and res_id hold their values until the next DONE.
- res_valid has no backpressure; consumers must sample it on the strobe.
- Requests arriving while busy are not accepted and are not lost while req_valid stays high.
- When several requesters are valid in IDLE, only the grant g is accepted. Fairness: under continuous requests from all N_REQ requesters, each is served once per N_REQ conversions.
- Reset mid-operation: the in-flight conversion is abandoned immediately and no res_valid is produced.
- The converter's own reset is not driven by this block.

Test Plan:
- Single request: bench stub makes conv_sig16b follow the low 16 bits of conv_double, delayed CONV_LAT cycles after conv_enable. Drive req 0 with 64'h0000_0000_0000_1234 -> req_ready[0] at accept; conv_enable one cycle later; res_valid in cycle t+3 with res_data=16'h1234, res_id=0; conv_count=1.
- Contention (N_REQ=2): both valid continuously, req 0 data ..A001, req 1 data ..B002 -> results alternate 0,1,0,1 with data A001/B002; results spaced 4 cycles apart at CONV_LAT=1.
- Latency (CONV_LAT=3): single request -> conv_enable at t+1, res_valid at t+5, busy high for cycles t+1..t+5.
- Saturation: stub returns 16'hFFFF, then 16'h7FFF, then 16'h0001 -> sat_count=2, conv_count=3; with both counters preloaded to FFFF the same results leave them at FFFF.
- Mid-operation reset: assert rst during WAIT -> all outputs 0 the same cycle; no res_valid after release; the first grant after reset goes to req 0 even if req 1 was pending.
- Hold while busy: req 1 asserts during req 0's conversion and holds -> req_ready[1] only in the IDLE cycle after DONE; res_id=1 is returned.
